// File: rtl/sample_frame_packer.sv
// sample_frame_packer: captures one complete multi-channel sample set and
// serialises it as a byte frame (optional sequence byte, then channel 0..N-1,
// each sample MSB byte first) for a downstream COBS encoder.
module sample_frame_packer #(
    parameter int NUM_CHANNELS  = 2,
    parameter int SAMPLE_WIDTH  = 16,
    parameter int SEQ_ENABLE    = 1,
    parameter int DROP_ON_STALL = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] s_tdata,
    input  logic [NUM_CHANNELS-1:0]              s_tvalid,
    output logic [NUM_CHANNELS-1:0]              s_tready,
    output logic [7:0]                           m_tdata,
    output logic                                 m_tvalid,
    input  logic                                 m_tready,
    output logic                                 m_tlast,
    output logic [15:0]                          drop_count
);

    localparam int SEQ_BYTES = (SEQ_ENABLE != 0) ? 1 : 0;
    localparam int FRAME_LEN = SEQ_BYTES + NUM_CHANNELS * SAMPLE_WIDTH / 8;
    localparam int FW        = FRAME_LEN * 8;
    localparam int IDX_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t           state;
    logic [FW-1:0]    frame_in;   // frame in transmit order, byte 0 at the top
    logic [FW-1:0]    frame_sr;   // remaining bytes; top byte is on m_tdata
    logic [IDX_W-1:0] byte_idx;
    logic [7:0]       seq;
    logic             all_valid;
    logic             drop_fire;
    logic             accept;

    // Reorder lanes so channel 0 lands right below the sequence byte.
    genvar k;
    generate
        for (k = 0; k < NUM_CHANNELS; k++) begin : g_lane
            assign frame_in[(NUM_CHANNELS-1-k)*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
                s_tdata[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end
        if (SEQ_BYTES != 0) begin : g_seq
            // The counter only moves at frame end, so it already holds the
            // value this frame must carry.
            assign frame_in[FW-1 -: 8] = seq;
        end
    endgenerate

    // Only a complete set ever handshakes; mid-frame sets are swallowed when dropping.
    assign all_valid = &s_tvalid;
    assign drop_fire = (DROP_ON_STALL != 0) && (state == EMIT) && all_valid;
    assign accept    = !rst && (((state == IDLE) && all_valid) || drop_fire);
    assign s_tready  = {NUM_CHANNELS{accept}};
    assign m_tdata   = frame_sr[FW-1 -: 8];

    // Frame FSM: capture in IDLE, shift out one byte per downstream handshake in EMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            frame_sr <= '0;
            byte_idx <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            seq      <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (all_valid) begin
                        frame_sr <= frame_in;
                        byte_idx <= '0;
                        m_tvalid <= 1'b1;
                        m_tlast  <= (FRAME_LEN == 1);
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (m_tready) begin
                        if (m_tlast) begin
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            seq      <= seq + 8'd1;
                            state    <= IDLE;
                        end else begin
                            frame_sr <= frame_sr << 8;
                            byte_idx <= byte_idx + IDX_W'(1);
                            m_tlast  <= ((byte_idx + IDX_W'(1)) == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating count of sample sets discarded while a frame is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_count <= 16'd0;
        else if (drop_fire && (drop_count != 16'hFFFF))
            drop_count <= drop_count + 16'd1;
    end

endmodule
